capture_readout_arbiter: RTL and testbench

Sequences the readout of a completed capture from the two channel sample RAMs to the Tx protocol. It sits between the request handler, the buffer controller (capture-complete flag and last write address), the channel RAMs and the Tx protocol mux. It arbitrates pending CH1/CH2 requests, computes the oldest-sample address, and streams `num_samples` bytes per request with an rdy/ack/eof handshake.

---
 rtl/capture_readout_arbiter.sv | 129 ++++++++++++
 tb/tb_capture_readout_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/capture_readout_arbiter.sv
// Readout sequencer: arbitrates CH1/CH2 readout requests and streams the
// oldest-first window of a finished capture from the channel RAMs to Tx.
module capture_readout_arbiter #(
  parameter int BITS_ADC       = 8,
  parameter int RAM_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rqst_ch1,
  input  logic                      rqst_ch2,
  input  logic                      capture_done,
  input  logic [RAM_ADDR_WIDTH-1:0] last_addr,
  input  logic [15:0]               num_samples,
  output logic                      ram_rd_en,
  output logic [RAM_ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [BITS_ADC-1:0]       ram_ch1_data,
  input  logic [BITS_ADC-1:0]       ram_ch2_data,
  output logic [BITS_ADC-1:0]       tx_data,
  output logic                      tx_rdy,
  output logic                      tx_eof,
  input  logic                      tx_ack,
  output logic                      busy
);

  // state  | meaning
  // S_IDLE | waiting for a pending request and a held capture
  // S_READ | RAM read strobe issued for addr_q
  // S_CAPT | RAM data valid, register it into tx_data
  // S_SEND | byte presented to Tx, waiting for tx_ack
  typedef enum logic [1:0] {S_IDLE, S_READ, S_CAPT, S_SEND} state_t;

  localparam logic [16:0]               DEPTH    = 17'(1) << RAM_ADDR_WIDTH;
  localparam logic [RAM_ADDR_WIDTH-1:0] ADDR_ONE = RAM_ADDR_WIDTH'(1);

  state_t                    state_q;
  logic                      pend1_q, pend2_q;
  logic                      sel_q;
  logic [RAM_ADDR_WIDTH-1:0] count_q;
  logic [RAM_ADDR_WIDTH-1:0] addr_q;
  logic                      rd_en_q;
  logic [RAM_ADDR_WIDTH-1:0] rd_addr_q;
  logic [BITS_ADC-1:0]       tx_data_q;
  logic                      tx_rdy_q, tx_eof_q, busy_q;

  logic                      pend1_d, pend2_d;
  logic                      accept_d, acc_ch2_d, n_zero_d;
  logic [16:0]               n_eff_d;
  logic [RAM_ADDR_WIDTH-1:0] count_init_d, start_addr_d;

  // start = last - (N-1); for a full-depth window this lands on last+1
  always_comb begin
    n_eff_d      = ({1'b0, num_samples} > DEPTH) ? DEPTH : {1'b0, num_samples};
    n_zero_d     = (num_samples == 16'd0);
    count_init_d = RAM_ADDR_WIDTH'(n_eff_d - 17'd1);
    start_addr_d = last_addr - count_init_d;
    accept_d     = (state_q == S_IDLE) && capture_done && (pend1_q || pend2_q);
    acc_ch2_d    = ~pend1_q;
    pend1_d      = (pend1_q & ~(accept_d & ~acc_ch2_d)) | rqst_ch1;
    pend2_d      = (pend2_q & ~(accept_d &  acc_ch2_d)) | rqst_ch2;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pend1_q   <= 1'b0;
      pend2_q   <= 1'b0;
      sel_q     <= 1'b0;
      count_q   <= '0;
      addr_q    <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      tx_data_q <= '0;
      tx_rdy_q  <= 1'b0;
      tx_eof_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      pend1_q <= pend1_d;
      pend2_q <= pend2_d;
      case (state_q)
        S_IDLE: begin
          if (accept_d && !n_zero_d) begin
            state_q   <= S_READ;
            sel_q     <= acc_ch2_d;
            count_q   <= count_init_d;
            addr_q    <= start_addr_d;
            rd_en_q   <= 1'b1;
            rd_addr_q <= start_addr_d;
            busy_q    <= 1'b1;
          end
        end
        S_READ: begin
          rd_en_q <= 1'b0;
          state_q <= S_CAPT;
        end
        S_CAPT: begin
          tx_data_q <= sel_q ? ram_ch2_data : ram_ch1_data;
          tx_rdy_q  <= 1'b1;
          tx_eof_q  <= (count_q == '0);
          state_q   <= S_SEND;
        end
        S_SEND: begin
          if (tx_ack) begin
            tx_rdy_q <= 1'b0;
            tx_eof_q <= 1'b0;
            if (count_q == '0) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              count_q   <= count_q - ADDR_ONE;
              addr_q    <= addr_q + ADDR_ONE;
              rd_en_q   <= 1'b1;
              rd_addr_q <= addr_q + ADDR_ONE;
              state_q   <= S_READ;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ram_rd_en   = rd_en_q;
  assign ram_rd_addr = rd_addr_q;
  assign tx_data     = tx_data_q;
  assign tx_rdy      = tx_rdy_q;
  assign tx_eof      = tx_eof_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_capture_readout_arbiter.sv
// Directed bench for capture_readout_arbiter with a synchronous-read RAM model.
module tb_capture_readout_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rqst_ch1 = 1'b0, rqst_ch2 = 1'b0, capture_done = 1'b0;
  logic [11:0] last_addr = '0;
  logic [15:0] num_samples = '0;
  logic        ram_rd_en;
  logic [11:0] ram_rd_addr;
  logic [7:0]  ram_ch1_data = '0, ram_ch2_data = '0;
  logic [7:0]  tx_data;
  logic        tx_rdy, tx_eof;
  logic        tx_ack = 1'b0;
  logic        busy;

  int checks = 0;
  int failures = 0;

  capture_readout_arbiter #(.BITS_ADC(8), .RAM_ADDR_WIDTH(12)) dut (
    .clk(clk), .rst(rst), .rqst_ch1(rqst_ch1), .rqst_ch2(rqst_ch2),
    .capture_done(capture_done), .last_addr(last_addr), .num_samples(num_samples),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
    .ram_ch1_data(ram_ch1_data), .ram_ch2_data(ram_ch2_data),
    .tx_data(tx_data), .tx_rdy(tx_rdy), .tx_eof(tx_eof), .tx_ack(tx_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram1(input logic [11:0] a);
    return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram2(input logic [11:0] a);
    return (a[7:0] + 8'h3C) ^ {a[11:8], 4'h9};
  endfunction

  always @(posedge clk) begin
    if (ram_rd_en) begin
      ram_ch1_data <= ram1(ram_rd_addr);
      ram_ch2_data <= ram2(ram_rd_addr);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic c1, input logic c2);
    rqst_ch1 = c1;
    rqst_ch2 = c2;
    @(negedge clk);
    rqst_ch1 = 1'b0;
    rqst_ch2 = 1'b0;
  endtask

  // Follows one readout: start latency, per-byte address/data/eof, hold under
  // back-pressure, 3-cycle byte period and busy dropping after the last ack.
  task automatic readout(input string tag, input logic ch2, input logic [11:0] start,
                         input int n, input int ack_dly, input int exp_lat,
                         input logic scramble);
    int          waited = 0;
    logic [11:0] a;
    logic [7:0]  d;
    logic        e;
    while (!ram_rd_en && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_start_lat"}, waited, exp_lat);
    if (!ram_rd_en) return;
    for (int i = 0; i < n; i++) begin
      a = start + 12'(i);
      d = ch2 ? ram2(a) : ram1(a);
      e = (i == n - 1);
      if (i > 0) check({tag, "_rd_en"}, ram_rd_en, 1);
      check({tag, "_addr"}, ram_rd_addr, a);
      if (scramble && i == 0) begin
        last_addr    = 12'($urandom);
        num_samples  = 16'($urandom);
        capture_done = 1'b0;
      end
      @(negedge clk);
      check({tag, "_rdy_capt"}, tx_rdy, 0);
      @(negedge clk);
      check({tag, "_byte"}, {tx_rdy, tx_eof, tx_data}, {1'b1, e, d});
      for (int k = 0; k < ack_dly; k++) begin
        @(negedge clk);
        check({tag, "_hold"}, {tx_rdy, tx_eof, ram_rd_en, tx_data}, {1'b1, e, 1'b0, d});
      end
      tx_ack = 1'b1;
      @(negedge clk);
      tx_ack = 1'b0;
      check({tag, "_rdy_fall"}, tx_rdy, 0);
    end
    check({tag, "_end"}, {busy, tx_eof, ram_rd_en}, 3'b000);
  endtask

  initial begin
    int          seen;
    int          waited;

    // reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rqst_ch1     = 1'($urandom);
      rqst_ch2     = 1'($urandom);
      capture_done = 1'($urandom);
      last_addr    = 12'($urandom);
      num_samples  = 16'($urandom);
      tx_ack       = 1'($urandom);
    end
    #1;
    check("reset_outputs", {ram_rd_en, ram_rd_addr, tx_data, tx_rdy, tx_eof, busy}, 0);
    @(negedge clk);
    rqst_ch1 = 0; rqst_ch2 = 0; capture_done = 0; tx_ack = 0;
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_idle", {busy, ram_rd_en, tx_rdy}, 0);

    // single CH1: 0x00D..0x010
    capture_done = 1'b1;
    last_addr = 12'h010; num_samples = 16'd4;
    pulse(1, 0);
    readout("ch1", 0, 12'h00D, 4, 0, 1, 0);

    // wrap on CH2: 0xFFE, 0xFFF, 0x000, 0x001, 0x002
    last_addr = 12'h002; num_samples = 16'd5;
    pulse(0, 1);
    readout("wrap", 1, 12'hFFE, 5, 0, 1, 0);

    // simultaneous requests, CH1 first, CH2 two cycles after last CH1 ack
    last_addr = 12'h345; num_samples = 16'd3;
    pulse(1, 1);
    readout("sim1", 0, 12'h343, 3, 0, 1, 0);
    readout("sim2", 1, 12'h343, 3, 0, 1, 0);

    // pending while no capture is held
    capture_done = 1'b0;
    last_addr = 12'h080; num_samples = 16'd2;
    pulse(0, 1);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ram_rd_en || busy) seen = 1;
    end
    check("pend_no_read", seen, 0);
    capture_done = 1'b1;
    readout("pend", 1, 12'h07F, 2, 0, 1, 0);

    // back-pressure, inputs changed and capture_done dropped mid-readout
    last_addr = 12'h7FF; num_samples = 16'd3;
    pulse(1, 0);
    readout("bp", 0, 12'h7FD, 3, 7, 1, 1);
    capture_done = 1'b1;

    // clamp: 5000 requested, 4096 sent starting at last+1
    last_addr = 12'h123; num_samples = 16'd5000;
    pulse(1, 0);
    readout("clamp", 0, 12'h124, 4096, 0, 1, 0);

    // N=0 consumes the request without sending
    num_samples = 16'd0;
    pulse(1, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ram_rd_en || busy || tx_rdy) seen = 1;
    end
    check("n0_no_send", seen, 0);
    num_samples = 16'd2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ram_rd_en || busy) seen = 1;
    end
    check("n0_consumed", seen, 0);

    // reset during 2nd SEND of a 10-byte readout, start 0x200-9 = 0x1F7
    last_addr = 12'h200; num_samples = 16'd10;
    pulse(1, 0);
    waited = 0;
    while (!ram_rd_en && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("mid_start", {ram_rd_en, ram_rd_addr}, {1'b1, 12'h1F7});
    @(negedge clk);
    @(negedge clk);
    check("mid_byte1", {tx_rdy, tx_data}, {1'b1, ram1(12'h1F7)});
    tx_ack = 1'b1;
    @(negedge clk);
    tx_ack = 1'b0;
    check("mid_read2", {ram_rd_en, ram_rd_addr}, {1'b1, 12'h1F8});
    @(negedge clk);
    @(negedge clk);
    check("mid_byte2", {tx_rdy, tx_data}, {1'b1, ram1(12'h1F8)});
    #2 rst = 1'b0;
    #1;
    check("mid_async_rst", {tx_rdy, tx_eof, busy, ram_rd_en, tx_data}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    pulse(1, 0);
    readout("restart", 0, 12'h1F7, 10, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
